// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: data memory + MEM/WB register, sized loads/stores, load-latency stall; `MEM_MISALIGN_TRAP_EN adds misalignment trapping
module mem_stage_lsu #(
  parameter int XLEN     = 32,
  parameter int DEPTH    = 64,
  parameter int LOAD_LAT = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] ALUResultM,
  input  logic [XLEN-1:0] WriteDataM,
  input  logic [XLEN-1:0] PCPlus4M,
  input  logic [4:0]      RDM,
  input  logic            RegWriteM,
  input  logic            MemWriteM,
  input  logic            MemReadM,
  input  logic [2:0]      Funct3M,
  input  logic [1:0]      ResultSrcM,
  input  logic            FlushW,
  output logic            StallM,
  output logic [XLEN-1:0] ALUResultW,
  output logic [XLEN-1:0] ReadDataW,
  output logic [XLEN-1:0] PCPlus4W,
  output logic [4:0]      RDW,
  output logic            RegWriteW,
  output logic [1:0]      ResultSrcW
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic            MisalignW
`endif
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t state, state_n;
  logic [2:0] cnt, cnt_n;
  logic [XLEN-1:0] mem [DEPTH];
  logic [AW-1:0] idx;
  logic [1:0] lane;
  logic mis, load, go, we;
  logic [3:0] be;
  logic [XLEN-1:0] wdata, word, rdata;
  logic [7:0] b;
  logic [15:0] h;
  assign idx  = ALUResultM[AW+1:2];
  assign lane = ALUResultM[1:0];
`ifdef MEM_MISALIGN_TRAP_EN
  assign mis = (MemReadM | MemWriteM) &
               (((Funct3M == 3'b001 || Funct3M == 3'b101) & ALUResultM[0]) |
                ((Funct3M == 3'b010) & (|ALUResultM[1:0])));
`else
  assign mis = 1'b0;
`endif
  assign load = MemReadM & ~MemWriteM & ~mis;
  assign go   = (LOAD_LAT > 0) && load;
  assign we   = MemWriteM & (state == IDLE) & ~mis;
  assign be = Funct3M == 3'b000 ? 4'b0001 << lane :
              Funct3M == 3'b001 ? (lane[1] ? 4'b1100 : 4'b0011) :
              Funct3M == 3'b010 ? 4'b1111 : 4'b0000;
  assign wdata = Funct3M[1:0] == 2'b00 ? {4{WriteDataM[7:0]}} :
                 Funct3M[1:0] == 2'b01 ? {2{WriteDataM[15:0]}} : WriteDataM;
  always_ff @(posedge clk)
    for (int i = 0; i < 4; i++)
      if (we && be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
  assign word = mem[idx];
  assign b    = word[{lane, 3'b000} +: 8];
  assign h    = lane[1] ? word[31:16] : word[15:0];
  always_comb
    rdata = mis                 ? '0 :
            Funct3M == 3'b000   ? {{24{b[7]}}, b} :
            Funct3M == 3'b001   ? {{16{h[15]}}, h} :
            Funct3M == 3'b010   ? word :
            Funct3M == 3'b100   ? {24'h0, b} :
            Funct3M == 3'b101   ? {16'h0, h} : '0;
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      cnt   <= 3'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  always_comb begin
    state_n = state == IDLE ? (go ? WAIT : IDLE) : (cnt == 3'd0 ? IDLE : WAIT);
    cnt_n   = state == IDLE ? (go ? 3'(LOAD_LAT - 1) : cnt) : (cnt == 3'd0 ? cnt : cnt - 3'd1);
  end
  always_comb StallM = state == IDLE ? go : (cnt != 3'd0);
  // flushed and stalled cycles both leave a bubble so writeback never sees a half-done load
  always_ff @(posedge clk)
    if (reset || FlushW || StallM) begin
      ALUResultW <= '0;
      ReadDataW  <= '0;
      PCPlus4W   <= '0;
      RDW        <= '0;
      RegWriteW  <= 1'b0;
      ResultSrcW <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
      MisalignW  <= 1'b0;
`endif
    end else begin
      ALUResultW <= ALUResultM;
      ReadDataW  <= rdata;
      PCPlus4W   <= PCPlus4M;
      RDW        <= RDM;
      RegWriteW  <= RegWriteM & ~mis;
      ResultSrcW <= ResultSrcM;
`ifdef MEM_MISALIGN_TRAP_EN
      MisalignW  <= mis;
`endif
    end
endmodule
